// File: rtl/hilo_muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl_if
//   Bundles the EX-stage request signals and the HI/LO sequencer responses.
//
//   Handshake: start is the request-valid and ~busy is the ready. A request is
//   taken on a rising clock edge only when start=1 and busy=0. While stall=1
//   the requester must hold start/op/a/b stable, and they are ignored.
//
//   master (pipeline side) drives: start, op, a, b, mf_req
//   slave  (sequencer side) drives: busy, stall, hi_out, lo_out, hilo_write
// -----------------------------------------------------------------------------
interface hilo_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mf_req;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             hilo_write;

   modport master (
      output start, op, a, b, mf_req,
      input  busy, stall, hi_out, lo_out, hilo_write
   );

   modport slave (
      input  start, op, a, b, mf_req,
      output busy, stall, hi_out, lo_out, hilo_write
   );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   HI/LO sequencer beside the EX stage. Runs iterative multiply (shift-add)
//   and restoring divide, one step per cycle for WIDTH cycles, then applies
//   sign correction and loads the architectural HI/LO pair. MTHI/MTLO load
//   HI/LO directly in one edge.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        slave modport: start/op/a/b/mf_req in; busy/stall/hi_out/
//              lo_out/hilo_write out
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hilo_muldiv_ctrl_if.slave      bus,
   output logic [1:0]             dbg_state
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   // Upper half: multiply accumulator / divide remainder.
   // Lower half: multiplier being shifted out / dividend shifting into quotient.
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] opnd_q;      // multiplicand or divisor magnitude
   logic             is_div_q;
   logic             sign_xor_q;  // product / quotient negative
   logic             sign_a_q;    // remainder takes dividend sign
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             hilo_write_q;

   // Request decode
   logic idle_accept, op_md, op_signed, op_mt;
   logic a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      op_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
      op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      op_mt     = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
      idle_accept = (state_q == S_IDLE) && bus.start;
      a_neg     = op_signed && bus.a[WIDTH-1];
      b_neg     = op_signed && bus.b[WIDTH-1];
      a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
      b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
   end

   // One iteration step for each algorithm
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      // Remainder shifted left with the next dividend bit; the carry bit is
      // kept because it can exceed WIDTH bits before the trial subtract.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
      if (div_diff[WIDTH+1]) begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction applied in FIX
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;

   always_comb begin
      mul_res = sign_xor_q ? (~acc_q + 1'b1) : acc_q;
      quo     = acc_q[WIDTH-1:0];
      rem     = acc_q[2*WIDTH-1:WIDTH];
      // With a zero divisor every trial subtract succeeds, so the quotient
      // would be all ones in magnitude and the remainder is |A|; the sign fix
      // on the remainder then restores A. Only LO needs overriding.
      if (dbz_q) begin
         div_lo = {WIDTH{1'b1}};
      end else begin
         div_lo = sign_xor_q ? (~quo + 1'b1) : quo;
      end
      div_hi  = sign_a_q ? (~rem + 1'b1) : rem;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (idle_accept && op_md) state_d = S_CALC;
         S_CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         S_FIX:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and architectural HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         acc_q        <= '0;
         opnd_q       <= '0;
         is_div_q     <= 1'b0;
         sign_xor_q   <= 1'b0;
         sign_a_q     <= 1'b0;
         dbz_q        <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         hilo_write_q <= 1'b0;
      end else begin
         hilo_write_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (idle_accept && op_md) begin
                  cnt_q      <= '0;
                  acc_q      <= {{WIDTH{1'b0}}, a_mag};
                  opnd_q     <= b_mag;
                  is_div_q   <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                  sign_xor_q <= a_neg ^ b_neg;
                  sign_a_q   <= a_neg && (bus.op == OP_DIV);
                  dbz_q      <= (bus.b == '0);
               end else if (idle_accept && op_mt) begin
                  if (bus.op == OP_MTHI) hi_q <= bus.a;
                  else                   lo_q <= bus.a;
                  hilo_write_q <= 1'b1;
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q + 1'b1;
               acc_q <= is_div_q ? div_next : mul_next;
            end
            S_FIX: begin
               if (is_div_q) begin
                  hi_q <= div_hi;
                  lo_q <= div_lo;
               end else begin
                  hi_q <= mul_res[2*WIDTH-1:WIDTH];
                  lo_q <= mul_res[WIDTH-1:0];
               end
               hilo_write_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.stall      = bus.busy && (bus.start || bus.mf_req);
   assign bus.hi_out     = hi_q;
   assign bus.lo_out     = lo_q;
   assign bus.hilo_write = hilo_write_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

   localparam int W = 32;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

   hilo_muldiv_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [2*W-1:0] exp_q[$];
   int             n_cmp = 0;
   int             n_err = 0;
   logic [W-1:0]   model_hi = '0;
   logic [W-1:0]   model_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every HI/LO write pulse must match the oldest expected result.
   always @(negedge clk) begin : monitor
      logic [2*W-1:0] e;
      if (rst_n && bus.hilo_write) begin
         check("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("hilo_value", {bus.hi_out, bus.lo_out}, e);
         end
      end
   end

   // ---------------- driver tasks (all enter/leave at posedge+1) ----------------
   task automatic wait_idle();
      int t = 0;
      while (bus.busy && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   task automatic md_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
      int lat = 0;
      wait_idle();
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      exp_q.push_back({eh, el});
      model_hi = eh; model_lo = el;
      @(posedge clk); #1;
      // Operands wander while the op runs; the result must not care.
      bus.start = 1'b0; bus.op = OP_NONE; bus.a = $urandom; bus.b = $urandom;
      while (bus.busy && lat < 100) begin
         lat++;
         @(posedge clk); #1;
      end
      check({name, "_busy_cycles"}, 64'(lat), 64'd33);
   endtask

   task automatic mt_op(input logic [2:0] op, input logic [W-1:0] a);
      bus.start = 1'b1; bus.op = op; bus.a = a;
      if (op == OP_MTHI) model_hi = a; else model_lo = a;
      exp_q.push_back({model_hi, model_lo});
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.op = OP_NONE; bus.a = '0; bus.b = '0; bus.mf_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   64'(bus.busy), 64'd0);
      check("rst_write",  64'(bus.hilo_write), 64'd0);
      check("rst_hi",     64'(bus.hi_out), 64'd0);
      check("rst_lo",     64'(bus.lo_out), 64'd0);
      check("rst_state",  64'(dbg_state), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Mid-CALC reset: HI set first so clearing is observable.
      mt_op(OP_MTHI, 32'hAAAA_AAAA);
      bus.start = 1'b0;
      repeat (3) @(posedge clk); #1;
      bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = OP_NONE;
      repeat (10) @(posedge clk); #1;
      check("midcalc_state", 64'(dbg_state), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy",  64'(bus.busy), 64'd0);
      check("midrst_write", 64'(bus.hilo_write), 64'd0);
      check("midrst_hi",    64'(bus.hi_out), 64'd0);
      check("midrst_lo",    64'(bus.lo_out), 64'd0);
      check("midrst_state", 64'(dbg_state), 64'd0);
      model_hi = '0; model_lo = '0;
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(posedge clk); #1;
      check("postrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
      check("postrst_busy", 64'(bus.busy), 64'd0);

      // Multiply / divide vectors (hand-computed results)
      md_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
      md_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
      md_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
      md_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a");
      md_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_neg_b");
      md_op(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0");
      md_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");
      md_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
      md_op(OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, "divu_big");

      // MTHI then MTLO on consecutive cycles
      mt_op(OP_MTHI, 32'h0000_1234);
      mt_op(OP_MTLO, 32'h0000_5678);
      bus.start = 1'b0; bus.op = OP_NONE;
      repeat (2) @(posedge clk); #1;
      check("mt_hilo", {bus.hi_out, bus.lo_out}, {32'h0000_1234, 32'h0000_5678});

      // Ignored ops: none / reserved
      bus.start = 1'b1; bus.op = OP_NONE; bus.a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.op = OP_RSVD;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ign_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(posedge clk); #1;
      check("ign_hilo", {bus.hi_out, bus.lo_out}, {model_hi, model_lo});

      // Stall during busy MULT, second op held and accepted when busy falls
      bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd6;
      exp_q.push_back({32'd0, 32'd30});
      @(posedge clk); #1;
      bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.mf_req = 1'b1;
      for (int n = 1; n <= 34; n++) begin
         check("b2b_stall", 64'(bus.stall), 64'(n <= 33));
         check("b2b_busy",  64'(bus.busy),  64'(n <= 33));
         if (n == 34) begin
            exp_q.push_back({32'd2, 32'd14});
            model_hi = 32'd2; model_lo = 32'd14;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.mf_req = 1'b0; bus.op = OP_NONE;
      begin
         int lat = 0;
         while (bus.busy && lat < 100) begin
            lat++;
            @(posedge clk); #1;
         end
         check("b2b_second_busy_cycles", 64'(lat), 64'd33);
      end
      repeat (3) @(posedge clk); #1;
      check("final_hilo",    {bus.hi_out, bus.lo_out}, {model_hi, model_lo});
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
